wb_ring_writer: RTL and testbench

//  Wishbone classic master that drains a valid/ready stream of 32-bit measurement words into a

---
 rtl/wb_ring_writer.sv | 222 ++++++++++++++++++++++
 tb/tb_wb_ring_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ring_writer.sv
// wb_ring_writer: Wishbone classic write master that drains a valid/ready stream of 32-bit
// samples into a circular buffer held in the port B side of a dual-port RAM.
// A small input FIFO decouples the sample source from the bus. The write pointer, the
// wrap count and a sticky bus-error flag are exported to the CPU register block.
// Optional feature: define WB_RING_WRITER_IRQ_EN to add irq_o. irq_o pulses for one cycle
// when the ring pointer reaches the half-way index and again when it wraps to zero.
module wb_ring_writer #(
  parameter int ADDR_WIDTH     = 14,
  parameter int BASE_ADDR      = 0,
  parameter int DEPTH_WORDS    = 256,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [31:0]                    s_data_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic                           en_i,
  input  logic                           clr_i,
  output logic [ADDR_WIDTH-1:0]          m_adr_o,
  output logic [31:0]                    m_dat_o,
  output logic                           m_we_o,
  output logic [3:0]                     m_sel_o,
  output logic                           m_stb_o,
  output logic                           m_cyc_o,
  input  logic                           m_ack_i,
  input  logic                           m_stall_i,
  output logic [$clog2(DEPTH_WORDS)-1:0] wr_ptr_o,
  output logic [15:0]                    wrap_cnt_o,
  output logic                           busy_o,
`ifdef WB_RING_WRITER_IRQ_EN
  output logic                           irq_o,
`endif
  output logic                           err_o
);

  localparam int PTR_W  = $clog2(DEPTH_WORDS);
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int TICK_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  // Input FIFO
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [FA_W-1:0] r_wr_idx, r_rd_idx;
  logic [FA_W:0]   r_count;
  logic [FA_W-1:0] w_rd_idx_inc;
  logic            w_full, w_empty, w_push;
  logic [31:0]     w_head, w_head_next;

  // Bus side
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic                  r_cyc, r_stb, r_err;
  logic [PTR_W-1:0]      r_wr_ptr, w_ptr_inc;
  logic                  w_ptr_last;
  logic [15:0]           r_wrap_cnt;
  logic [TICK_W-1:0]     r_tick;

  // FSM decisions
  logic w_start, w_take, w_continue, w_err_set;

  // Byte address of a ring slot.
  function automatic logic [ADDR_WIDTH-1:0] f_adr(input logic [PTR_W-1:0] ptr);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({ptr, 2'b00});
  endfunction

  assign w_full       = (r_count == (FA_W+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign s_ready_o    = !w_full && !r_err;
  assign w_push       = s_valid_i && s_ready_o;
  assign w_rd_idx_inc = r_rd_idx + 1'b1;
  assign w_head       = r_mem[r_rd_idx];
  assign w_head_next  = r_mem[w_rd_idx_inc];

  assign w_ptr_last = (r_wr_ptr == PTR_W'(DEPTH_WORDS - 1));
  assign w_ptr_inc  = w_ptr_last ? '0 : r_wr_ptr + 1'b1;

  assign m_adr_o    = r_adr;
  assign m_dat_o    = r_dat;
  assign m_cyc_o    = r_cyc;
  assign m_stb_o    = r_stb;
  assign m_we_o     = r_cyc;
  assign m_sel_o    = {4{r_cyc}};
  assign wr_ptr_o   = r_wr_ptr;
  assign wrap_cnt_o = r_wrap_cnt;
  assign busy_o     = (r_state != S_IDLE);
  assign err_o      = r_err;

  // FIFO storage: write the incoming sample into the tail slot.
  // NOTE: the storage array has no reset; only the indices and count need one, and leaving
  // the array out of reset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_idx] <= s_data_i;
  end

  // FIFO indices and occupancy; clr_i flushes the FIFO like a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_take) r_rd_idx <= w_rd_idx_inc;
      case ({w_push, w_take})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state logic and per-cycle bus decisions.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take       = 1'b0;
    w_continue   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && en_i && !r_err) begin
          w_start      = 1'b1;
          w_state_next = S_BUS;
        end
      end
      S_BUS: begin
        // A stall outranks an ack seen in the same cycle: the word stays in the FIFO.
        if (m_stall_i) begin
          w_err_set    = 1'b1;
          w_state_next = S_ERR;
        end else if (m_ack_i) begin
          w_take = 1'b1;
          // Keep the cycle open only if another word is already waiting behind the popped one.
          if (r_count > (FA_W+1)'(1) && en_i) begin
            w_continue = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (r_tick == TICK_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_set    = 1'b1;
          w_state_next = S_ERR;
        end
      end
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and registered bus outputs; clr_i cancels everything like a reset.
  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_state    <= S_IDLE;
      r_adr      <= '0;
      r_dat      <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_err      <= 1'b0;
      r_wr_ptr   <= '0;
      r_wrap_cnt <= '0;
      r_tick     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_BUS) r_tick <= r_tick + 1'b1;

      if (w_start) begin
        r_cyc  <= 1'b1;
        r_stb  <= 1'b1;
        r_adr  <= f_adr(r_wr_ptr);
        r_dat  <= w_head;
        r_tick <= '0;
      end

      if (w_take) begin
        r_wr_ptr <= w_ptr_inc;
        r_tick   <= '0;
        if (w_ptr_last) r_wrap_cnt <= r_wrap_cnt + 16'd1;
        if (w_continue) begin
          r_adr <= f_adr(w_ptr_inc);
          r_dat <= w_head_next;
        end else begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
        end
      end

      if (w_err_set) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
        r_err <= 1'b1;
      end
    end
  end

`ifdef WB_RING_WRITER_IRQ_EN
  logic r_irq;

  // One-cycle pulse when an accepted write moves the pointer to the half mark or to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_take && ((w_ptr_inc == PTR_W'(DEPTH_WORDS / 2)) || (w_ptr_inc == '0));
    end
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_wb_ring_writer.sv
// Bench for wb_ring_writer: a small registered-ack RAM model, a push driver that queues the
// expected RAM writes, and a monitor that compares every write the RAM accepts.
module tb_wb_ring_writer;

  localparam int AW    = 14;
  localparam int BASE  = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          en = 1'b1;
  logic          clr = 1'b0;
  logic [AW-1:0] m_adr;
  logic [31:0]   m_dat;
  logic          m_we;
  logic [3:0]    m_sel;
  logic          m_stb;
  logic          m_cyc;
  logic          ram_ack;
  logic          ram_stall;
  logic [2:0]    wr_ptr;
  logic [15:0]   wrap_cnt;
  logic          busy;
  logic          err;
`ifdef WB_RING_WRITER_IRQ_EN
  logic          irq;
`endif

  wb_ring_writer #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .en_i(en), .clr_i(clr),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_stb_o(m_stb), .m_cyc_o(m_cyc), .m_ack_i(ram_ack), .m_stall_i(ram_stall),
    .wr_ptr_o(wr_ptr), .wrap_cnt_o(wrap_cnt), .busy_o(busy),
`ifdef WB_RING_WRITER_IRQ_EN
    .irq_o(irq),
`endif
    .err_o(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: registered ack one cycle after stb is sampled, ignores stb while ack is high,
  // raises the stall flag instead of ack for addresses at or above ram_limit.
  int ram_limit = 1 << AW;
  bit ack_en    = 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      ram_ack   <= 1'b0;
      ram_stall <= 1'b0;
    end else begin
      ram_ack   <= m_cyc && m_stb && !ram_ack && ack_en && (int'(m_adr) < ram_limit);
      ram_stall <= m_cyc && m_stb && !ram_ack && !(int'(m_adr) < ram_limit);
    end
  end

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wr_t;
  wr_t exp_q[$];
  int  exp_ptr  = 0;
  int  exp_wrap = 0;

  int stb_cnt = 0;
  int cyc_cnt = 0;
  int cyc_rise = 0;
  int irq_cnt = 0;
  bit cyc_prev = 1'b0;

  // Monitor: any write the RAM is about to accept at the next edge must match the queue head.
  always @(negedge clk) begin
    if (!rst && m_cyc && m_stb && !ram_ack && !ram_stall && ack_en && int'(m_adr) < ram_limit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {18'd0, m_adr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_adr", {18'd0, m_adr}, {18'd0, e.adr});
        check("wr_dat", m_dat, e.dat);
        check("wr_sel", {28'd0, m_sel}, 32'hF);
        check("wr_we", {31'd0, m_we}, 32'd1);
      end
    end
    if (m_stb) stb_cnt++;
    if (m_cyc) cyc_cnt++;
    if (m_cyc && !cyc_prev) cyc_rise++;
    cyc_prev = m_cyc;
`ifdef WB_RING_WRITER_IRQ_EN
    if (irq) irq_cnt++;
`endif
  end

  // Push one word; when exp_wr is set, also queue the RAM write it must produce.
  task automatic push(input logic [31:0] d, input bit exp_wr);
    int n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("push_ready_timeout", 32'd0, 32'd1);
      return;
    end
    s_data  = d;
    s_valid = 1'b1;
    if (exp_wr) begin
      exp_q.push_back('{AW'(BASE + 4 * exp_ptr), d});
      exp_ptr = (exp_ptr + 1) % DEPTH;
      if (exp_ptr == 0) exp_wrap++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy || exp_q.size() != 0}, 32'd0);
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, err}, 32'd1);
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!m_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, m_stb}, 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    exp_ptr  = 0;
    exp_wrap = 0;
  endtask

  initial begin
    int snap_a, snap_b;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_cyc", {31'd0, m_cyc}, 32'd0);
    check("rst_stb", {31'd0, m_stb}, 32'd0);
    check("rst_sel", {28'd0, m_sel}, 32'd0);
    check("rst_we", {31'd0, m_we}, 32'd0);
    check("rst_adr", {18'd0, m_adr}, 32'd0);
    check("rst_dat", m_dat, 32'd0);
    check("rst_ptr", {29'd0, wr_ptr}, 32'd0);
    check("rst_wrap", {16'd0, wrap_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // 1: single word, exact latency
    push(32'hDEAD_BEEF, 1'b1);
    check("t1_stb_n0", {31'd0, m_stb}, 32'd0);
    @(negedge clk);
    check("t1_stb_n1", {31'd0, m_stb}, 32'd1);
    check("t1_busy_n1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_ack_n2", {31'd0, ram_ack}, 32'd1);
    @(negedge clk);
    check("t1_cyc_n3", {31'd0, m_cyc}, 32'd0);
    check("t1_busy_n3", {31'd0, busy}, 32'd0);
    check("t1_ptr", {29'd0, wr_ptr}, 32'd1);

    // 2: burst of four, one open cycle, 2 strobe cycles per word
    snap_a = stb_cnt;
    snap_b = cyc_rise;
    push(32'h1111_0001, 1'b1);
    push(32'h2222_0002, 1'b1);
    push(32'h3333_0003, 1'b1);
    push(32'h4444_0004, 1'b1);
    wait_idle("t2_idle");
    check("t2_stb_cycles", stb_cnt - snap_a, 32'd8);
    check("t2_cyc_rises", cyc_rise - snap_b, 32'd1);
    check("t2_ptr", {29'd0, wr_ptr}, 32'd5);

    // 3: fill FIFO with writes disabled, then wrap the ring
    en = 1'b0;
    push(32'hA000_0005, 1'b1);
    push(32'hA000_0006, 1'b1);
    push(32'hA000_0007, 1'b1);
    push(32'hA000_0008, 1'b1);
    check("t3_full_ready", {31'd0, s_ready}, 32'd0);
    check("t3_hold_busy", {31'd0, busy}, 32'd0);
    check("t3_hold_ptr", {29'd0, wr_ptr}, 32'd5);
    en = 1'b1;
    wait_idle("t3_idle");
    check("t3_ptr", {29'd0, wr_ptr}, 32'd1);
    check("t3_wrap", {16'd0, wrap_cnt}, 32'd1);
`ifdef WB_RING_WRITER_IRQ_EN
    check("t3_irq_pulses", irq_cnt, 32'd2);
`endif

    // 4: address beyond the RAM -> stall -> sticky error, then clr recovers
    ram_limit = 0;
    push(32'hBAD0_0001, 1'b0);
    wait_err("t4_err");
    check("t4_cyc", {31'd0, m_cyc}, 32'd0);
    check("t4_ready", {31'd0, s_ready}, 32'd0);
    check("t4_ptr", {29'd0, wr_ptr}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd1);
    pulse_clr();
    ram_limit = 1 << AW;
    repeat (3) @(negedge clk);
    check("t4_clr_err", {31'd0, err}, 32'd0);
    check("t4_clr_ptr", {29'd0, wr_ptr}, 32'd0);
    check("t4_clr_wrap", {16'd0, wrap_cnt}, 32'd0);
    check("t4_clr_ready", {31'd0, s_ready}, 32'd1);
    check("t4_flushed", {31'd0, busy}, 32'd0);
    push(32'h600D_0001, 1'b1);
    wait_idle("t4_recover");
    check("t4_recover_ptr", {29'd0, wr_ptr}, 32'd1);

    // 5: no ack -> timeout after 15 bus cycles
    pulse_clr();
    ack_en = 1'b0;
    snap_a = cyc_cnt;
    push(32'h7100_0001, 1'b0);
    wait_err("t5_err");
    check("t5_cyc_cycles", cyc_cnt - snap_a, 32'd15);
    check("t5_cyc", {31'd0, m_cyc}, 32'd0);
    pulse_clr();
    ack_en = 1'b1;

    // 6: clr while strobing; the late ack must be ignored
    push(32'hC1C1_0001, 1'b1);
    wait_idle("t6_first");
    push(32'hC1C1_0002, 1'b1);
    wait_stb("t6_stb");
    pulse_clr();
    check("t6_cyc", {31'd0, m_cyc}, 32'd0);
    check("t6_ptr", {29'd0, wr_ptr}, 32'd0);
    check("t6_late_ack", {31'd0, ram_ack}, 32'd1);
    repeat (3) @(negedge clk);
    check("t6_ptr_after", {29'd0, wr_ptr}, 32'd0);
    check("t6_busy_after", {31'd0, busy}, 32'd0);
    push(32'hC1C1_0003, 1'b1);
    wait_idle("t6_recover");
    check("t6_recover_ptr", {29'd0, wr_ptr}, 32'd1);

    // 7: reset while strobing
    push(32'hE5E5_0001, 1'b1);
    wait_stb("t7_stb");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ptr  = 0;
    exp_wrap = 0;
    check("t7_cyc", {31'd0, m_cyc}, 32'd0);
    check("t7_adr", {18'd0, m_adr}, 32'd0);
    check("t7_ptr", {29'd0, wr_ptr}, 32'd0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_ready", {31'd0, s_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("t7_idle_after", {31'd0, busy}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
